// File: rtl/uart_pkg.sv
// uart_pkg: UART-path defaults (DATA_WIDTH_DEF, EOM_BYTE_DEF), arbiter state encoding, clog2 helper
package uart_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam logic [7:0] EOM_BYTE_DEF = 8'h0A;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic int clog2(input int unsigned v);
    int r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x >>= 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: round-robin select; req/last_grant in, one-hot grant and valid out
module rr_priority_picker import uart_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int IW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++)
      for (int j = 0; j < NUM_REQ; j++)
        if (!valid && req[j] && j == (int'(last_grant) + i) % NUM_REQ) begin
          grant[j] = 1'b1;
          valid = 1'b1;
        end
  end
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: message-granular round-robin share of one tx byte stream; req_* in, tx_* out, grant/busy status
module serial_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] EOM_BYTE = DATA_WIDTH'(EOM_BYTE_DEF),
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);
  localparam int IW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  arb_state_e state;
  logic [IW-1:0] last_grant, gidx;
  logic [CW-1:0] idle_cnt;
  logic [NUM_REQ-1:0] pick;
  logic pick_valid, stall, eom, expire;
  rr_priority_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req(req_valid),
    .last_grant(last_grant),
    .grant(pick),
    .valid(pick_valid)
  );
  always_comb begin
    tx_data = '0;
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        tx_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        gidx = IW'(i);
      end
  end
  assign tx_valid = |(grant & req_valid);
  assign req_ready = grant & {NUM_REQ{tx_ready}};
  // only an owner with nothing to offer is stalling; back-pressure keeps the counter cleared
  assign stall = (state == LOCKED) && !tx_valid;
  assign eom = tx_valid && tx_ready && (tx_data == EOM_BYTE);
  assign expire = (TIMEOUT_CYCLES != 0) && stall && (idle_cnt == LAST_IDLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      busy <= 1'b0;
      last_grant <= IW'(NUM_REQ - 1);
      idle_cnt <= '0;
    end else if (state == IDLE) begin
      idle_cnt <= '0;
      if (pick_valid) begin
        state <= LOCKED;
        grant <= pick;
        busy <= 1'b1;
      end
    end else if (eom || expire) begin
      state <= IDLE;
      grant <= '0;
      busy <= 1'b0;
      last_grant <= gidx;
      idle_cnt <= '0;
    end else begin
      idle_cnt <= !stall ? '0 : (idle_cnt == CNT_MAX) ? idle_cnt : idle_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: scoreboard bench for serial_tx_arbiter (3 requesters, timeout 8)
module tb_serial_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_ready = 1'b1;
  logic [23:0] req_data;
  logic [2:0] req_valid, req_ready, grant, acc, prev_g;
  logic [7:0] tx_data;
  logic tx_valid, busy;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mon_idx;
  logic [7:0] src_q[3][$];
  logic [7:0] exp_q[3][$];
  logic [7:0] tx_log[$];
  int tx_cyc[$];
  logic [2:0] g_log[$];
  int g_cyc[$];

  serial_tx_arbiter #(
    .NUM_REQ(3),
    .DATA_WIDTH(8),
    .EOM_BYTE(8'h0A),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .grant(grant),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // requester model: each requester presents the head of its queue and pops it once accepted
  initial begin
    req_valid = '0;
    req_data = '0;
    acc = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        req_valid[i] = src_q[i].size() > 0;
        req_data[i*8 +: 8] = req_valid[i] ? src_q[i][0] : 8'h00;
      end
    end
  end

  // monitor: scoreboard compare of every transfer against the owning requester's queue
  always @(negedge clk) begin
    acc = rst_n ? (req_valid & req_ready) : 3'b000;
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(|grant));
      chk("onehot", 32'($countones(grant) <= 1), 32'(1));
      if (grant != prev_g) begin
        g_log.push_back(grant);
        g_cyc.push_back(cyc);
      end
      if (tx_valid && tx_ready) begin
        mon_idx = 0;
        for (int i = 0; i < 3; i++) if (grant[i]) mon_idx = i;
        chk("sb_expected", 32'(exp_q[mon_idx].size() > 0), 32'(1));
        if (exp_q[mon_idx].size() > 0) chk("sb_data", 32'(tx_data), 32'(exp_q[mon_idx].pop_front()));
        tx_log.push_back(tx_data);
        tx_cyc.push_back(cyc);
      end
    end
    prev_g = grant;
  end

  task automatic send(input int r, input logic [63:0] seq, input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = seq[(n-1-k)*8 +: 8];
      src_q[r].push_back(b);
      exp_q[r].push_back(b);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tx_log.delete();
    tx_cyc.delete();
    g_log.delete();
    g_cyc.delete();
  endtask

  task automatic wait_done(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      #1;
      done = src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 && grant == 3'b000;
    end
    chk({tag, "_done"}, 32'(done), 32'(1));
    chk({tag, "_lost"}, 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'(0));
  endtask

  task automatic wait_grant(input string tag, input logic [2:0] g);
    bit hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk);
      #1;
      hit = grant == g;
    end
    chk({tag, "_grant"}, 32'(hit), 32'(1));
  endtask

  task automatic wait_tx(input string tag, input int n);
    bit hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk);
      #1;
      hit = tx_log.size() >= n;
    end
    chk({tag, "_tx"}, 32'(hit), 32'(1));
  endtask

  task automatic chk_glog(input string tag, input int n, input logic [63:0] seq);
    chk({tag, "_gn"}, 32'(g_log.size()), 32'(n));
    for (int k = 0; k < n && k < g_log.size(); k++)
      chk({tag, "_g"}, 32'(g_log[k]), 32'(seq[(n-1-k)*4 +: 3]));
  endtask

  task automatic chk_tx(input string tag, input int n, input logic [63:0] seq);
    chk({tag, "_tn"}, 32'(tx_log.size()), 32'(n));
    for (int k = 0; k < n && k < tx_log.size(); k++)
      chk({tag, "_t"}, 32'(tx_log[k]), 32'(seq[(n-1-k)*8 +: 8]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    #1;
    chk("rst_state", 32'({grant, busy, tx_valid, req_ready, tx_data}), 32'(0));
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      chk("idle", 32'({grant, busy, tx_valid, req_ready}), 32'(0));
    end

    do_reset();
    send(0, 64'h48490A, 3);
    send(1, 64'h520A, 2);
    wait_done("t2");
    chk_tx("t2", 5, 64'h48490A520A);
    chk_glog("t2", 4, 64'h1020);
    if (tx_cyc.size() >= 5) begin
      chk("t2_d1", 32'(tx_cyc[1] - tx_cyc[0]), 32'(1));
      chk("t2_d2", 32'(tx_cyc[2] - tx_cyc[1]), 32'(1));
      chk("t2_gap", 32'(tx_cyc[3] - tx_cyc[2]), 32'(2));
      chk("t2_d4", 32'(tx_cyc[4] - tx_cyc[3]), 32'(1));
    end
    if (g_cyc.size() >= 3) chk("t2_idle1", 32'(g_cyc[2] - g_cyc[1]), 32'(1));

    do_reset();
    for (int i = 0; i < 3; i++) send(i, 64'h0A0A, 2);
    wait_done("t3");
    chk_tx("t3", 6, 64'h0A0A0A0A0A0A);
    chk_glog("t3", 12, 64'h102040102040);
    for (int k = 1; k < 12 && k < g_cyc.size(); k++)
      chk("t3_cyc", 32'(g_cyc[k] - g_cyc[k-1]), 32'(1));

    do_reset();
    tx_ready = 1'b0;
    send(0, 64'h410A, 2);
    wait_grant("t4", 3'b001);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      chk("t4_hold", 32'({tx_valid, tx_data, req_ready, grant}), 32'({1'b1, 8'h41, 3'b000, 3'b001}));
    end
    @(posedge clk);
    #2 tx_ready = 1'b1;
    wait_done("t4");
    chk_tx("t4", 2, 64'h410A);
    chk_glog("t4", 2, 64'h10);

    do_reset();
    send(0, 64'h41, 1);
    send(1, 64'h520A, 2);
    wait_grant("t5", 3'b010);
    send(0, 64'h420A, 2);
    wait_done("t5");
    chk_tx("t5", 5, 64'h41520A420A);
    chk_glog("t5", 6, 64'h102010);
    if (g_cyc.size() >= 3 && tx_cyc.size() >= 1) begin
      chk("t5_release", 32'(g_cyc[1] - tx_cyc[0]), 32'(9));
      chk("t5_regrant", 32'(g_cyc[2] - g_cyc[1]), 32'(1));
    end

    do_reset();
    send(0, 64'h41, 1);
    send(1, 64'h520A, 2);
    wait_tx("t6", 1);
    repeat (7) @(posedge clk);
    #2 send(0, 64'h0A, 1);
    wait_done("t6");
    chk_tx("t6", 4, 64'h410A520A);
    chk_glog("t6", 4, 64'h1020);
    if (g_cyc.size() >= 3 && tx_cyc.size() >= 2) begin
      chk("t6_eom", 32'(tx_cyc[1] - tx_cyc[0]), 32'(8));
      chk("t6_release", 32'(g_cyc[1] - tx_cyc[0]), 32'(9));
      chk("t6_regrant", 32'(g_cyc[2] - g_cyc[1]), 32'(1));
    end

    do_reset();
    send(0, 64'h48490A, 3);
    wait_tx("t7", 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async", 32'({grant, req_ready, tx_valid, busy}), 32'(0));
    do_reset();
    repeat (10) @(negedge clk);
    #1;
    chk("t7_no_tx", 32'(tx_log.size()), 32'(0));
    chk("t7_no_grant", 32'(g_log.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
